// File: rtl/msg_schedule_ctrl.sv
// SHA-256 message-schedule sequencer: loads 16 words, expands to W[0..ROUNDS-1] over a 16-slot ring.
// Optional abort input enabled by defining MSG_SCHED_ABORT_EN.
module msg_schedule_ctrl #(
    parameter int ROUNDS = 64
) (
    input  logic        clock,
    input  logic        reset,
`ifdef MSG_SCHED_ABORT_EN
    input  logic        abort,
`endif
    input  logic        start,
    input  logic [31:0] block_word,
    input  logic        block_word_valid,
    output logic        block_word_ready,
    output logic [31:0] wt,
    output logic        wt_valid,
    input  logic        wt_ready,
    output logic [5:0]  t_index,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_t;
    localparam logic [5:0] LAST = 6'(ROUNDS - 1);

    state_t      state;
    logic [31:0] sbuf [16];
    logic [3:0]  load_cnt;
    logic [5:0]  n;
    logic [3:0]  ni;
    logic [31:0] w_next;

    function automatic logic [31:0] s0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    // Ring slots wrap naturally in 4-bit arithmetic, giving the mod-16 addressing.
    always_comb begin
        n  = t_index + 6'd1;
        ni = n[3:0];
        if (n < 6'd16)
            w_next = sbuf[ni];
        else
            w_next = s1(sbuf[ni - 4'd2]) + sbuf[ni - 4'd7] + s0(sbuf[ni - 4'd15]) + sbuf[ni];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            load_cnt         <= 4'd0;
            block_word_ready <= 1'b0;
            wt               <= 32'd0;
            wt_valid         <= 1'b0;
            t_index          <= 6'd0;
            busy             <= 1'b0;
            done             <= 1'b0;
            for (int i = 0; i < 16; i++) sbuf[i] <= 32'd0;
        end else begin
            done <= 1'b0;
`ifdef MSG_SCHED_ABORT_EN
            if (abort) begin
                state            <= IDLE;
                load_cnt         <= 4'd0;
                block_word_ready <= 1'b0;
                wt_valid         <= 1'b0;
                busy             <= 1'b0;
            end else
`endif
            case (state)
                IDLE: if (start) begin
                    state            <= LOAD;
                    load_cnt         <= 4'd0;
                    block_word_ready <= 1'b1;
                    busy             <= 1'b1;
                end
                LOAD: if (block_word_valid && block_word_ready) begin
                    sbuf[load_cnt] <= block_word;
                    load_cnt       <= load_cnt + 4'd1;
                    if (load_cnt == 4'd15) begin
                        state            <= EXPAND;
                        block_word_ready <= 1'b0;
                        wt               <= sbuf[0];
                        wt_valid         <= 1'b1;
                        t_index          <= 6'd0;
                    end
                end
                EXPAND: if (wt_ready) begin
                    // Retiring W[t] into its slot frees nothing the next word still needs.
                    sbuf[t_index[3:0]] <= wt;
                    if (t_index == LAST) begin
                        wt_valid <= 1'b0;
                        state    <= DONE;
                        done     <= 1'b1;
                    end else begin
                        wt      <= w_next;
                        t_index <= t_index + 6'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_msg_schedule_ctrl.sv
// Scoreboard bench for msg_schedule_ctrl: reference schedule computed per block, monitor pops on output handshake.
module tb_msg_schedule_ctrl;
    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] block_word;
    logic        block_word_valid;
    logic        block_word_ready;
    logic [31:0] wt;
    logic        wt_valid;
    logic        wt_ready;
    logic [5:0]  t_index;
    logic        busy;
    logic        done;
`ifdef MSG_SCHED_ABORT_EN
    logic        abort = 1'b0;
`endif

    msg_schedule_ctrl dut (
        .clock(clock), .reset(reset),
`ifdef MSG_SCHED_ABORT_EN
        .abort(abort),
`endif
        .start(start), .block_word(block_word), .block_word_valid(block_word_valid),
        .block_word_ready(block_word_ready), .wt(wt), .wt_valid(wt_valid),
        .wt_ready(wt_ready), .t_index(t_index), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct {logic [31:0] w; logic [5:0] t;} exp_t;
    exp_t        q[$];
    int          checks = 0, errors = 0;
    logic [31:0] abc[16];
    logic [31:0] rm[16];
    int          rmode = 0;
    bit          stalled = 0, abc_mode = 0, pend_done = 0, stall_prev = 0;
    logic [31:0] hold_w;
    logic [5:0]  hold_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int s);
        return (x >> s) | (x << (32 - s));
    endfunction

    // Reference: plain SHA-256 schedule recurrence over a full 64-entry array.
    task automatic push_block(input logic [31:0] m[16]);
        logic [31:0] w[64];
        for (int t = 0; t < 64; t++) begin
            if (t < 16) w[t] = m[t];
            else w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                      + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
            q.push_back('{w[t], 6'(t)});
        end
    endtask

    // Output monitor / scoreboard.
    always @(negedge clock) begin
        if (reset) begin
            exp_t e;
            if (stall_prev && wt_valid) begin
                chk("stall_wt", 64'(wt), 64'(hold_w));
                chk("stall_t", 64'(t_index), 64'(hold_t));
            end
            stall_prev = wt_valid && !wt_ready;
            hold_w = wt;
            hold_t = t_index;
            chk("done", 64'(done), 64'(pend_done));
            pend_done = 0;
            if (wt_valid && wt_ready) begin
                if (q.size() == 0) chk("extra_word", 64'(t_index), 64'hFFFF);
                else begin
                    e = q.pop_front();
                    chk("wt", 64'(wt), 64'(e.w));
                    chk("t_index", 64'(t_index), 64'(e.t));
                    if (abc_mode)
                        case (e.t)
                            6'd0:  chk("abc_W0", 64'(wt), 64'h61626380);
                            6'd15: chk("abc_W15", 64'(wt), 64'h00000018);
                            6'd16: chk("abc_W16", 64'(wt), 64'h61626380);
                            6'd17: chk("abc_W17", 64'(wt), 64'h000F0000);
                            6'd18: chk("abc_W18", 64'(wt), 64'h7DA86405);
                            6'd63: chk("abc_W63", 64'(wt), 64'h12B1EDEB);
                            default: ;
                        endcase
                    if (e.t == 6'd63) pend_done = 1;
                end
            end
        end else begin
            stall_prev = 0;
            pend_done  = 0;
        end
    end

    // Consumer backpressure generator.
    initial begin
        wt_ready = 1'b1;
        forever begin
            @(posedge clock); #1;
            case (rmode)
                0: wt_ready = 1'b1;
                1: wt_ready = 1'($urandom_range(0, 1));
                default:
                    if (!stalled && wt_valid && t_index == 6'd20) begin
                        wt_ready = 1'b0;
                        repeat (4) begin @(posedge clock); #1; end
                        stalled = 1;
                    end else wt_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic check_idle_zero(input string tag);
        chk({tag, "_wt"}, 64'(wt), 0);
        chk({tag, "_wt_valid"}, 64'(wt_valid), 0);
        chk({tag, "_ready"}, 64'(block_word_ready), 0);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_done"}, 64'(done), 0);
        chk({tag, "_t_index"}, 64'(t_index), 0);
    endtask

    task automatic load_block(input logic [31:0] m[16], input bit bubbles, input bit spurious,
                              input int abort_at);
        int n;
        push_block(m);
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (bubbles) repeat ($urandom_range(0, 2)) begin
                block_word_valid = 1'b0;
                @(posedge clock); #1;
            end
            if (spurious) start = 1'($urandom_range(0, 1));
            block_word       = m[i];
            block_word_valid = 1'b1;
            if (i == abort_at) begin
`ifdef MSG_SCHED_ABORT_EN
                abort = 1'b1;
`endif
            end
            n = 0;
            while (!block_word_ready && n < 50) begin @(posedge clock); #1; n++; end
            if (n >= 50) begin
                chk("load_timeout", 0, 1);
                block_word_valid = 1'b0;
                start = 1'b0;
                return;
            end
            @(posedge clock); #1;
            if (i == abort_at) begin
`ifdef MSG_SCHED_ABORT_EN
                abort = 1'b0;
`endif
                block_word_valid = 1'b0;
                start = 1'b0;
                return;
            end
        end
        block_word_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 3000) begin @(negedge clock); n++; end
        chk("done_seen", 64'(done), 1);
        chk("queue_empty", 64'(q.size()), 0);
    endtask

    task automatic wait_t(input logic [5:0] t);
        int n = 0;
        do begin @(negedge clock); n++; end while (!(wt_valid && t_index == t) && n < 500);
        chk("reach_t", 64'(t_index), 64'(t));
    endtask

    initial begin
        int n;
        abc[0] = 32'h61626380;
        for (int i = 1; i < 15; i++) abc[i] = 32'd0;
        abc[15] = 32'h00000018;
        reset = 1'b0; start = 1'b0; block_word = 32'd0; block_word_valid = 1'b0;

        // T1: reset state, then reset reasserted mid-idle
        repeat (3) @(negedge clock);
        check_idle_zero("rst0");
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1 check_idle_zero("rst_idle");
        @(negedge clock) reset = 1'b1;

        // T2: "abc" block, full throughput
        abc_mode = 1; rmode = 0;
        load_block(abc, 0, 0, -1);
        n = 0;
        while (n < 200) begin
            @(negedge clock);
            if (!wt_valid) break;
            n++;
        end
        chk("throughput", 64'(n), 64);
        chk("t2_done", 64'(done), 1);
        chk("t2_queue_empty", 64'(q.size()), 0);

        // T3: stall at t=20 then random backpressure
        stalled = 0; rmode = 2;
        load_block(abc, 0, 0, -1);
        wait_done();

        // T4: bubbles, spurious start in LOAD/EXPAND/DONE
        rmode = 1;
        load_block(abc, 1, 1, -1);
        repeat (10) @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        wait_done();
        start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        repeat (2) begin
            @(negedge clock);
            chk("done_start_busy", 64'(busy), 0);
            chk("done_start_ready", 64'(block_word_ready), 0);
        end

        // T5: reset during EXPAND at t=30
        rmode = 0;
        load_block(abc, 0, 0, -1);
        wait_t(6'd30);
        reset = 1'b0;
        #1 q.delete();
        check_idle_zero("rst_mid");
        @(negedge clock) reset = 1'b1;
        load_block(abc, 0, 0, -1);
        wait_done();

`ifdef MSG_SCHED_ABORT_EN
        // T6: abort during LOAD and coincident with the W[40] handshake
        load_block(abc, 0, 0, 7);
        q.delete();
        @(negedge clock);
        chk("abort_load_busy", 64'(busy), 0);
        chk("abort_load_ready", 64'(block_word_ready), 0);
        load_block(abc, 0, 0, -1);
        wait_t(6'd40);
        abort = 1'b1;
        @(posedge clock); #1 abort = 1'b0;
        q.delete();
        @(negedge clock);
        chk("abort_exp_valid", 64'(wt_valid), 0);
        chk("abort_exp_busy", 64'(busy), 0);
        repeat (3) @(negedge clock);
        load_block(abc, 0, 0, -1);
        wait_done();
`endif

        // Random blocks with bubbles and random backpressure
        abc_mode = 0; rmode = 1;
        repeat (3) begin
            foreach (rm[i]) rm[i] = $urandom;
            load_block(rm, 1, 0, -1);
            wait_done();
        end

        repeat (3) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
